fx2_fifo_scheduler: RTL and testbench

- Sequences the shared FX2LP slave-FIFO bus (FD, SLRDN/SLWRN/SLOEN/FIFOADR/PKTENDN) on IFCLK between two requesters.
- DAC playback reads bytes from EP2 (FIFOADR=00) at a programmable rate.
- ADC capture writes bytes to EP6 (FIFOADR=10) through a small internal FIFO.
- Handles bus turnaround, fair arbitration, and short-packet commit; sits between the QsysCore PIO registers and the FX2 pins.

---
 rtl/fx2_fifo_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_fx2_fifo_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_scheduler.sv
`timescale 1ns/1ps
// FX2LP slave-FIFO bus scheduler: DAC playback reads EP2, ADC capture writes EP6
// through a small FIFO, with round-robin arbitration and idle short-packet commit.
module fx2_fifo_scheduler #(
    parameter int unsigned RATE_W      = 26,
    parameter int unsigned WFIFO_DEPTH = 8,
    parameter int unsigned PKT_TIMEOUT = 4096
) (
    input  logic              IFCLK,
    input  logic              RESET_N,
    input  logic [RATE_W-1:0] DAC_PERIOD,
    output logic [7:0]        DAC_DATA,
    output logic              DAC_VALID,
    input  logic [7:0]        ADC_DATA,
    input  logic              ADC_STB,
    input  logic              CLR_STATUS,
    output logic              DAC_UNDERRUN,
    output logic              ADC_OVERFLOW,
    input  logic [7:0]        FD_I,
    output logic [7:0]        FD_O,
    output logic              FD_OE,
    output logic              SLRDN,
    output logic              SLWRN,
    output logic              SLOEN,
    output logic [1:0]        FIFOADR,
    output logic              PKTENDN,
    input  logic [2:0]        FLAGN
);

    localparam int unsigned AW = $clog2(WFIFO_DEPTH);
    localparam int unsigned TW = $clog2(PKT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_OE, RD_STB, WR_ADDR, WR_STB, PKTEND
    } state_t;

    typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

    state_t            state, state_next;
    grant_t            last_grant;

    logic [RATE_W-1:0] tick_cnt;
    logic              tick, rd_pend, rd_issue, rd_req, wr_req;
    logic              underrun_set, overflow_set;

    logic [7:0]        fifo_mem [WFIFO_DEPTH];
    logic [AW:0]       wptr, rptr;
    logic              fifo_empty, fifo_full, push, pop;
    logic [7:0]        head;

    logic [8:0]        byte_cnt;
    logic [TW-1:0]     idle_cnt;
    logic              pkt_req, idle_run;

    logic              rd_fast, wr_fast;
    logic              slrdn_n, slwrn_n, sloen_n, fd_oe_n, pktendn_n;
    logic [1:0]        fifoadr_n;
    logic [7:0]        fd_o_n;

    logic              unused_flag;
    assign unused_flag = FLAGN[0];

    always_comb begin
        tick         = (DAC_PERIOD != '0) && (tick_cnt == DAC_PERIOD - RATE_W'(1));
        rd_issue     = (state_next == RD_STB);
        underrun_set = tick && rd_pend && !rd_issue;
        rd_req       = rd_pend && FLAGN[2];
        fifo_empty   = (wptr == rptr);
        fifo_full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        pop          = (state == WR_STB);
        push         = ADC_STB && (!fifo_full || pop);
        overflow_set = ADC_STB && fifo_full && !pop;
        wr_req       = !fifo_empty && FLAGN[1];
        head         = fifo_mem[rptr[AW-1:0]];
        idle_run     = (byte_cnt != '0) && fifo_empty && (state != WR_STB) && !pkt_req;
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tick_cnt     <= '0;
            rd_pend      <= 1'b0;
            DAC_UNDERRUN <= 1'b0;
            ADC_OVERFLOW <= 1'b0;
        end else begin
            if ((DAC_PERIOD == '0) || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + RATE_W'(1);
            // A tick coinciding with the strobe issue becomes the next pending read
            rd_pend <= tick || (rd_pend && !rd_issue);
            if (underrun_set)
                DAC_UNDERRUN <= 1'b1;
            else if (CLR_STATUS)
                DAC_UNDERRUN <= 1'b0;
            if (overflow_set)
                ADC_OVERFLOW <= 1'b1;
            else if (CLR_STATUS)
                ADC_OVERFLOW <= 1'b0;
        end
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + (AW+1)'(1);
            if (pop)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge IFCLK) begin
        if (push)
            fifo_mem[wptr[AW-1:0]] <= ADC_DATA;
    end

    always_comb begin
        rd_fast    = (FIFOADR == 2'b00) && !SLOEN;
        wr_fast    = (FIFOADR == 2'b10) && FD_OE;
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_req && (!wr_req || last_grant == GRANT_WR))
                    state_next = rd_fast ? RD_STB : RD_ADDR;
                else if (wr_req)
                    state_next = wr_fast ? WR_STB : WR_ADDR;
                else if (pkt_req)
                    state_next = PKTEND;
            end
            RD_ADDR: state_next = RD_OE;
            RD_OE:   state_next = RD_STB;
            RD_STB:  state_next = IDLE;
            WR_ADDR: state_next = WR_STB;
            WR_STB:  state_next = IDLE;
            PKTEND:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every output is a flop
    always_comb begin
        slrdn_n   = 1'b1;
        slwrn_n   = 1'b1;
        pktendn_n = 1'b1;
        sloen_n   = SLOEN;
        fd_oe_n   = FD_OE;
        fifoadr_n = FIFOADR;
        fd_o_n    = FD_O;
        case (state_next)
            RD_ADDR: begin
                fd_oe_n   = 1'b0;
                sloen_n   = 1'b1;
                fifoadr_n = 2'b00;
            end
            RD_OE, RD_STB: begin
                fd_oe_n   = 1'b0;
                sloen_n   = 1'b0;
                fifoadr_n = 2'b00;
                slrdn_n   = (state_next != RD_STB);
            end
            WR_ADDR, WR_STB: begin
                sloen_n   = 1'b1;
                fd_oe_n   = 1'b1;
                fifoadr_n = 2'b10;
                fd_o_n    = head;
                slwrn_n   = (state_next != WR_STB);
            end
            PKTEND: begin
                fifoadr_n = 2'b10;
                pktendn_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            last_grant <= GRANT_WR;
            SLRDN      <= 1'b1;
            SLWRN      <= 1'b1;
            PKTENDN    <= 1'b1;
            SLOEN      <= 1'b1;
            FD_OE      <= 1'b0;
            FD_O       <= '0;
            FIFOADR    <= 2'b00;
            DAC_DATA   <= '0;
            DAC_VALID  <= 1'b0;
        end else begin
            state     <= state_next;
            SLRDN     <= slrdn_n;
            SLWRN     <= slwrn_n;
            PKTENDN   <= pktendn_n;
            SLOEN     <= sloen_n;
            FD_OE     <= fd_oe_n;
            FD_O      <= fd_o_n;
            FIFOADR   <= fifoadr_n;
            DAC_VALID <= (state == RD_STB);
            if (state == RD_STB) begin
                DAC_DATA   <= FD_I;
                last_grant <= GRANT_RD;
            end else if (state == WR_STB) begin
                last_grant <= GRANT_WR;
            end
        end
    end

    always_ff @(posedge IFCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_cnt <= '0;
            idle_cnt <= '0;
            pkt_req  <= 1'b0;
        end else begin
            if (state == PKTEND)
                byte_cnt <= '0;
            else if (state == WR_STB)
                byte_cnt <= byte_cnt + 9'd1;
            if ((state == WR_STB) || (byte_cnt == '0))
                idle_cnt <= '0;
            else if (idle_run)
                idle_cnt <= idle_cnt + TW'(1);
            if (state == PKTEND)
                pkt_req <= 1'b0;
            else if (idle_run && (idle_cnt == TW'(PKT_TIMEOUT - 1)))
                pkt_req <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fx2_fifo_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for fx2_fifo_scheduler: directed stimulus pushes expected bytes,
// a negedge monitor pops them on each DAC_VALID / SLWRN strobe and checks bus rules.
module tb_fx2_fifo_scheduler;

    localparam int unsigned RATE_W      = 26;
    localparam int unsigned WFIFO_DEPTH = 8;
    localparam int unsigned PKT_TIMEOUT = 4096;

    logic              IFCLK = 1'b0;
    logic              RESET_N;
    logic [RATE_W-1:0] DAC_PERIOD;
    logic [7:0]        DAC_DATA;
    logic              DAC_VALID;
    logic [7:0]        ADC_DATA;
    logic              ADC_STB;
    logic              CLR_STATUS;
    logic              DAC_UNDERRUN;
    logic              ADC_OVERFLOW;
    logic [7:0]        FD_I;
    logic [7:0]        FD_O;
    logic              FD_OE;
    logic              SLRDN;
    logic              SLWRN;
    logic              SLOEN;
    logic [1:0]        FIFOADR;
    logic              PKTENDN;
    logic [2:0]        FLAGN;

    fx2_fifo_scheduler #(
        .RATE_W(RATE_W),
        .WFIFO_DEPTH(WFIFO_DEPTH),
        .PKT_TIMEOUT(PKT_TIMEOUT)
    ) dut (
        .IFCLK(IFCLK), .RESET_N(RESET_N), .DAC_PERIOD(DAC_PERIOD),
        .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID),
        .ADC_DATA(ADC_DATA), .ADC_STB(ADC_STB), .CLR_STATUS(CLR_STATUS),
        .DAC_UNDERRUN(DAC_UNDERRUN), .ADC_OVERFLOW(ADC_OVERFLOW),
        .FD_I(FD_I), .FD_O(FD_O), .FD_OE(FD_OE),
        .SLRDN(SLRDN), .SLWRN(SLWRN), .SLOEN(SLOEN),
        .FIFOADR(FIFOADR), .PKTENDN(PKTENDN), .FLAGN(FLAGN)
    );

    always #10 IFCLK = ~IFCLK;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned base_cyc = 0;
    int          rd_count = 0, wr_count = 0, pkt_count = 0;
    int          rd_base = 0, wr_base = 0, pkt_base = 0;
    int unsigned last_wr_cyc = 0, last_pkt_cyc = 0;
    int unsigned rd_cyc_q[$];
    bit          kind_q[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_wr[$];
    bit          chk_wr_data = 1'b1;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic check_range(input string name, input longint actual, input longint lo, input longint hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slrdn"}, SLRDN, 1);
        check({tag, "_slwrn"}, SLWRN, 1);
        check({tag, "_pktendn"}, PKTENDN, 1);
        check({tag, "_sloen"}, SLOEN, 1);
        check({tag, "_fd_oe"}, FD_OE, 0);
        check({tag, "_fd_o"}, FD_O, 0);
        check({tag, "_fifoadr"}, FIFOADR, 0);
        check({tag, "_dac_data"}, DAC_DATA, 0);
        check({tag, "_dac_valid"}, DAC_VALID, 0);
        check({tag, "_underrun"}, DAC_UNDERRUN, 0);
        check({tag, "_overflow"}, ADC_OVERFLOW, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge IFCLK);
        exp_rd.delete();
        exp_wr.delete();
        rd_cyc_q.delete();
        kind_q.delete();
        RESET_N  = 1'b1;
        base_cyc = cyc;
        rd_base  = rd_count;
        wr_base  = wr_count;
        pkt_base = pkt_count;
    endtask

    task automatic do_reset();
        @(negedge IFCLK);
        RESET_N    = 1'b0;
        ADC_STB    = 1'b0;
        CLR_STATUS = 1'b0;
        release_reset();
    endtask

    task automatic adc_push(input logic [7:0] b, input bit expect_kept);
        ADC_STB  = 1'b1;
        ADC_DATA = b;
        if (expect_kept)
            exp_wr.push_back(b);
    endtask

    task automatic wait_wr(input string name, input int n, input int budget);
        int k = 0;
        while ((wr_count - wr_base) < n && k < budget) begin
            @(negedge IFCLK);
            k++;
        end
        check(name, wr_count - wr_base, n);
    endtask

    initial begin
        forever begin
            @(posedge IFCLK);
            cyc++;
        end
    end

    // EP2 model: FD_I advances right after each read strobe is sampled
    initial begin
        forever begin
            @(negedge IFCLK);
            if (!SLRDN) begin
                exp_rd.push_back(FD_I);
                @(posedge IFCLK);
                #1 FD_I = FD_I + 8'd1;
            end
        end
    end

    initial begin
        logic prev_fd_oe, prev_sloen;
        prev_fd_oe = 1'b0;
        prev_sloen = 1'b1;
        forever begin
            @(negedge IFCLK);
            check("bus_contention", FD_OE & ~SLOEN, 0);
            if (prev_sloen && !SLOEN)
                check("fd_oe_low_before_sloen", prev_fd_oe, 0);
            if (!SLRDN) begin
                rd_count++;
                rd_cyc_q.push_back(cyc);
                kind_q.push_back(1'b0);
                check("rd_fifoadr", FIFOADR, 0);
                check("rd_fd_oe", FD_OE, 0);
            end
            if (DAC_VALID) begin
                if (exp_rd.size() == 0)
                    check("dac_valid_unexpected", 1, 0);
                else
                    check("dac_data", DAC_DATA, exp_rd.pop_front());
            end
            if (!SLWRN) begin
                wr_count++;
                last_wr_cyc = cyc;
                kind_q.push_back(1'b1);
                check("wr_fifoadr", FIFOADR, 2);
                check("wr_fd_oe", FD_OE, 1);
                if (chk_wr_data) begin
                    if (exp_wr.size() == 0)
                        check("slwrn_unexpected", 1, 0);
                    else
                        check("fd_o", FD_O, exp_wr.pop_front());
                end
            end
            if (!PKTENDN) begin
                pkt_count++;
                last_pkt_cyc = cyc;
                check("pkt_fifoadr", FIFOADR, 2);
                check("pkt_slwrn", SLWRN, 1);
            end
            prev_fd_oe = FD_OE;
            prev_sloen = SLOEN;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sloen_bad;
        int          alt_bad;
        int          n_stop;
        int unsigned rd_exp_cyc [6] = '{7, 9, 13, 17, 21, 25};

        RESET_N    = 1'b0;
        DAC_PERIOD = '0;
        ADC_DATA   = '0;
        ADC_STB    = 1'b0;
        CLR_STATUS = 1'b0;
        FD_I       = 8'h00;
        FLAGN      = 3'b110;

        // Reset state
        repeat (3) @(negedge IFCLK);
        check_reset_outputs("reset");

        // Periodic DAC reads: full path first, then fast path every 4 cycles
        DAC_PERIOD = 26'd4;
        FD_I       = 8'h10;
        do_reset();
        sloen_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge IFCLK);
            if (i == 26)
                DAC_PERIOD = '0;
            if (rd_cyc_q.size() > 0 && SLOEN)
                sloen_bad++;
        end
        check("t1_read_count", rd_count - rd_base, 6);
        for (int k = 0; k < 6 && k < rd_cyc_q.size(); k++)
            check($sformatf("t1_read_cycle_%0d", k), rd_cyc_q[k] - base_cyc, rd_exp_cyc[k]);
        check("t1_sloen_steady_low", sloen_bad, 0);
        check("t1_last_dac_data", DAC_DATA, 8'h15);
        check("t1_no_underrun", DAC_UNDERRUN, 0);
        check("t1_rd_scoreboard_empty", exp_rd.size(), 0);

        // Three ADC bytes then one idle-timeout packet commit
        do_reset();
        @(negedge IFCLK) adc_push(8'hA1, 1'b1);
        @(negedge IFCLK) adc_push(8'hA2, 1'b1);
        @(negedge IFCLK) adc_push(8'hA3, 1'b1);
        @(negedge IFCLK) ADC_STB = 1'b0;
        wait_wr("t2_write_count", 3, 50);
        for (int k = 0; k < PKT_TIMEOUT + 20 && pkt_count == pkt_base; k++)
            @(negedge IFCLK);
        check("t2_pktend_seen", pkt_count - pkt_base, 1);
        check_range("t2_pktend_delay", longint'(last_pkt_cyc) - longint'(last_wr_cyc),
                    PKT_TIMEOUT, PKT_TIMEOUT + 2);
        repeat (200) @(negedge IFCLK);
        check("t2_single_pktend", pkt_count - pkt_base, 1);
        check("t2_wr_scoreboard_empty", exp_wr.size(), 0);

        // 512 bytes: byte count wraps to 0, so no packet end
        do_reset();
        for (int i = 0; i < 512; i++) begin
            @(negedge IFCLK) adc_push(8'(i) ^ 8'h3C, 1'b1);
            @(negedge IFCLK) ADC_STB = 1'b0;
            @(negedge IFCLK);
        end
        wait_wr("t3_write_count", 512, 100);
        repeat (PKT_TIMEOUT + 50) @(negedge IFCLK);
        check("t3_no_pktend", pkt_count - pkt_base, 0);
        check("t3_no_overflow", ADC_OVERFLOW, 0);
        check("t3_wr_scoreboard_empty", exp_wr.size(), 0);

        // Competing DAC and ADC traffic: strict alternation once both request
        DAC_PERIOD  = 26'd2;
        FD_I        = 8'h40;
        chk_wr_data = 1'b0;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge IFCLK) adc_push(8'(i), 1'b0);
            @(negedge IFCLK) ADC_STB = 1'b0;
        end
        DAC_PERIOD = '0;
        n_stop     = kind_q.size();
        alt_bad    = 0;
        for (int k = 1; k < n_stop; k++)
            if (kind_q[k] == kind_q[k-1])
                alt_bad++;
        check("t4_alternation", alt_bad, 0);
        check("t4_first_grant_is_read", (n_stop > 0) ? kind_q[0] : 1'b1, 0);
        check_range("t4_reads", rd_count - rd_base, 10, 100);
        check_range("t4_writes", wr_count - wr_base, 10, 100);
        check("t4_underrun", DAC_UNDERRUN, 1);
        check("t4_overflow", ADC_OVERFLOW, 1);
        repeat (60) @(negedge IFCLK);
        check("t4_rd_scoreboard_empty", exp_rd.size(), 0);

        // EP6 full: ninth byte dropped, then drain and clear the sticky flag
        FLAGN = 3'b100;
        do_reset();
        chk_wr_data = 1'b1;
        for (int i = 0; i < 9; i++)
            @(negedge IFCLK) adc_push(8'hB0 + 8'(i), i < 8);
        @(negedge IFCLK) ADC_STB = 1'b0;
        repeat (20) @(negedge IFCLK);
        check("t5_no_write_while_full", wr_count - wr_base, 0);
        check("t5_overflow_set", ADC_OVERFLOW, 1);
        FLAGN = 3'b110;
        wait_wr("t5_drain_count", 8, 100);
        check("t5_overflow_sticky", ADC_OVERFLOW, 1);
        @(negedge IFCLK) CLR_STATUS = 1'b1;
        @(negedge IFCLK) CLR_STATUS = 1'b0;
        check("t5_overflow_cleared", ADC_OVERFLOW, 0);
        check("t5_wr_scoreboard_empty", exp_wr.size(), 0);

        // EP2 empty: no reads, underrun on the second tick
        FLAGN      = 3'b010;
        DAC_PERIOD = 26'd4;
        do_reset();
        repeat (7) @(negedge IFCLK);
        check("t6_no_underrun_after_first_tick", DAC_UNDERRUN, 0);
        @(negedge IFCLK);
        check("t6_underrun_at_second_tick", DAC_UNDERRUN, 1);
        repeat (20) @(negedge IFCLK);
        check("t6_no_reads", rd_count - rd_base, 0);

        // Reset asserted during a write strobe
        FLAGN      = 3'b110;
        DAC_PERIOD = '0;
        do_reset();
        @(negedge IFCLK) adc_push(8'hC7, 1'b1);
        @(negedge IFCLK) ADC_STB = 1'b0;
        for (int k = 0; k < 20 && SLWRN; k++)
            @(negedge IFCLK);
        check("t7_strobe_reached", SLWRN, 0);
        #2 RESET_N = 1'b0;
        #1 check_reset_outputs("t7_async");
        release_reset();
        repeat (30) @(negedge IFCLK);
        check("t7_no_retry", wr_count - wr_base, 0);
        check("t7_no_pktend", pkt_count - pkt_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
